// File: rtl/cpld_crc_pkg.sv
// Shared state encoding, default polynomial/seed and a reference single-bit CRC-8 step.
// Optional checker ports on the top are enabled by defining CPLD_CRC8_CHECK_EN.
package cpld_crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] POLY_DEFAULT = 8'h07;
  localparam logic [7:0] INIT_DEFAULT = 8'h00;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic d,
                                           input logic [7:0] poly);
    return {crc[6:0], 1'b0} ^ ((d ^ crc[7]) ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/cpld_crc8_step.sv
// Combinational single-bit CRC-8 update; every polynomial tap is a three-input XOR
// of the shifted bit, the incoming data bit and the register MSB.
module cpld_crc8_step #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic [7:0] crc,
  input  logic       d,
  output logic [7:0] crc_next
);

  logic [7:0] shifted;

  assign shifted = {crc[6:0], 1'b0};

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    if (POLY[gi]) begin : g_tap
      assign crc_next[gi] = shifted[gi] ^ d ^ crc[7];
    end else begin : g_pass
      assign crc_next[gi] = shifted[gi];
    end
  end

endmodule

// File: rtl/cpld_crc8_serial.sv
// Serial CRC-8 accumulator with frame bit-length counter and valid/ack result hold.
// Define CPLD_CRC8_CHECK_EN to add the EXP compare input and registered ERR flag.
module cpld_crc8_serial
  import cpld_crc_pkg::*;
#(
  parameter logic [7:0] POLY = POLY_DEFAULT,
  parameter logic [7:0] INIT = INIT_DEFAULT,
  parameter int         LENW = 12
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            D0,
  input  logic            DV,
  input  logic            SOF,
  input  logic            EOF,
  output logic            RDY,
  output logic [7:0]      Q,
  output logic            QV,
  input  logic            QACK,
  output logic [LENW-1:0] LEN,
  output logic            LENOVF
`ifdef CPLD_CRC8_CHECK_EN
  ,
  input  logic [7:0]      EXP,
  output logic            ERR
`endif
);

  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);
  localparam logic [LENW-1:0] LEN_MAX = '1;

  state_t          state_reg, state_next;
  logic [7:0]      crc_reg, crc_next;
  logic [7:0]      q_reg, q_next;
  logic [LENW-1:0] len_reg, len_next;
  logic            ovf_reg, ovf_next;
  logic [7:0]      step_in, step_out;

  // A SOF bit always starts from the seed, whether from IDLE or aborting a frame.
  assign step_in = SOF ? INIT : crc_reg;

  cpld_crc8_step #(.POLY(POLY)) u_step (
    .crc      (step_in),
    .d        (D0),
    .crc_next (step_out)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= ST_IDLE;
      crc_reg   <= INIT;
      q_reg     <= 8'h00;
      len_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      crc_reg   <= crc_next;
      q_reg     <= q_next;
      len_reg   <= len_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    q_next     = q_reg;
    len_next   = len_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      ST_IDLE: begin
        if (DV && SOF) begin
          crc_next = step_out;
          len_next = LEN_ONE;
          ovf_next = 1'b0;
          if (EOF) begin
            state_next = ST_HOLD;
            q_next     = step_out;
          end else begin
            state_next = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (DV) begin
          crc_next = step_out;
          if (SOF) begin
            len_next = LEN_ONE;
            ovf_next = 1'b0;
          end else if (len_reg == LEN_MAX) begin
            ovf_next = 1'b1;
          end else begin
            len_next = len_reg + LEN_ONE;
          end
          if (EOF) begin
            state_next = ST_HOLD;
            q_next     = step_out;
          end
        end
      end
      ST_HOLD: begin
        if (QACK) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign RDY    = (state_reg != ST_HOLD);
  assign QV     = (state_reg == ST_HOLD);
  assign Q      = q_reg;
  assign LEN    = len_reg;
  assign LENOVF = ovf_reg;

`ifdef CPLD_CRC8_CHECK_EN
  logic err_reg;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      err_reg <= 1'b0;
    end else if (state_reg != ST_HOLD && state_next == ST_HOLD) begin
      err_reg <= (step_out != EXP);
    end else if (state_reg == ST_HOLD && QACK) begin
      err_reg <= 1'b0;
    end
  end

  assign ERR = err_reg;
`endif

endmodule

// File: tb/tb_cpld_crc8_serial.sv
// Self-checking bench for cpld_crc8_serial: table-driven frames plus hand-written
// sequences for hold, abort, saturation and reset; results go through a scoreboard queue.
`timescale 1ns/1ps
module tb_cpld_crc8_serial;

  localparam int LENW = 12;

  logic            CLK = 1'b0;
  logic            RSTN = 1'b0;
  logic            D0 = 1'b0;
  logic            DV = 1'b0;
  logic            SOF = 1'b0;
  logic            EOF = 1'b0;
  logic            QACK = 1'b0;
  logic            RDY;
  logic            QV;
  logic            LENOVF;
  logic [7:0]      Q;
  logic [LENW-1:0] LEN;
`ifdef CPLD_CRC8_CHECK_EN
  logic [7:0]      exp_in = 8'h00;
  logic            err;
`endif

  int checks = 0;
  int errors = 0;
  int qv_pulses = 0;
  logic qv_prev = 1'b0;

  typedef struct {
    logic [7:0] q;
    int         len;
    logic       ovf;
    logic       err;
  } res_t;

  typedef struct {
    logic [71:0] bits;
    int          nbits;
    logic [7:0]  q;
  } vec_t;

  res_t sb[$];
  res_t r;
  vec_t vecs[6];

  always #5 CLK = ~CLK;

  cpld_crc8_serial #(.LENW(LENW)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .D0     (D0),
    .DV     (DV),
    .SOF    (SOF),
    .EOF    (EOF),
    .RDY    (RDY),
    .Q      (Q),
    .QV     (QV),
    .QACK   (QACK),
    .LEN    (LEN),
`ifdef CPLD_CRC8_CHECK_EN
    .EXP    (exp_in),
    .ERR    (err),
`endif
    .LENOVF (LENOVF)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] q, input int len, input logic ovf);
    res_t e;
    e.q   = q;
    e.len = len;
    e.ovf = ovf;
`ifdef CPLD_CRC8_CHECK_EN
    e.err = (q != exp_in);
`else
    e.err = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic drive(input logic d, input logic v, input logic s, input logic e);
    @(negedge CLK);
    D0 = d; DV = v; SOF = s; EOF = e;
  endtask

  // One cycle after the EOF edge the result must already be valid.
  task automatic finish_frame(input string name);
    @(negedge CLK);
    check({name, "_qv_latency"}, 32'(QV), 1);
    check({name, "_rdy_low"}, 32'(RDY), 0);
    D0 = 1'b0; DV = 1'b0; SOF = 1'b0; EOF = 1'b0;
  endtask

  task automatic ack(input string name);
    @(negedge CLK);
    QACK = 1'b1;
    @(negedge CLK);
    QACK = 1'b0;
    check({name, "_ack_qv"}, 32'(QV), 0);
    check({name, "_ack_rdy"}, 32'(RDY), 1);
`ifdef CPLD_CRC8_CHECK_EN
    check({name, "_ack_err"}, 32'(err), 0);
`endif
  endtask

  // Scoreboard consumer: one pop per rising edge of QV.
  always @(negedge CLK) begin
    if (RSTN && QV && !qv_prev) begin
      qv_pulses++;
      if (sb.size() == 0) begin
        check("unexpected_qv", 32'(QV), 0);
      end else begin
        r = sb.pop_front();
        $display("result q=%02h len=%0d ovf=%0b (expect q=%02h len=%0d ovf=%0b)",
                 Q, LEN, LENOVF, r.q, r.len, r.ovf);
        check("q", 32'(Q), 32'(r.q));
        check("len", 32'(LEN), r.len);
        check("lenovf", 32'(LENOVF), 32'(r.ovf));
`ifdef CPLD_CRC8_CHECK_EN
        check("err", 32'(err), 32'(r.err));
`endif
      end
    end
    qv_prev = QV;
  end

  initial begin
    int pulses_before;

    vecs[0] = '{{8'h80, 64'd0}, 8, 8'h89};
    vecs[1] = '{72'h313233343536373839, 72, 8'hF4};
    vecs[2] = '{{1'b1, 71'd0}, 1, 8'h07};
    vecs[3] = '{{8'h00, 64'd0}, 8, 8'h00};
    vecs[4] = '{{8'hFF, 64'd0}, 8, 8'hF3};
    vecs[5] = '{{16'h0100, 56'd0}, 16, 8'h15};

    repeat (3) @(negedge CLK);
    check("rst_qv", 32'(QV), 0);
    check("rst_len", 32'(LEN), 0);
    check("rst_lenovf", 32'(LENOVF), 0);
    check("rst_rdy", 32'(RDY), 1);
    check("rst_q", 32'(Q), 0);
    RSTN = 1'b1;

    for (int k = 0; k < 6; k++) begin
      // DV without SOF, and a stray EOF, must be ignored while idle.
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      push(vecs[k].q, vecs[k].nbits, 1'b0);
      for (int i = 0; i < vecs[k].nbits; i++)
        drive(vecs[k].bits[71-i], 1'b1, i == 0, i == vecs[k].nbits - 1);
      finish_frame("vec");
      if (k == 1) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge CLK);
          check("hold_q", 32'(Q), 32'h F4);
          check("hold_qv", 32'(QV), 1);
          check("hold_rdy", 32'(RDY), 0);
          check("hold_len", 32'(LEN), 72);
          D0 = 1'($urandom_range(0, 1));
          DV = 1'b1;
          SOF = 1'($urandom_range(0, 1));
          EOF = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        DV = 1'b0; SOF = 1'b0; EOF = 1'b0;
      end
      ack("vec");
      check("retain_q", 32'(Q), 32'(vecs[k].q));
    end

    // Abort: SOF re-asserted after three bits, then byte 0x01.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    pulses_before = qv_pulses;
    push(8'h07, 8, 1'b0);
    for (int i = 0; i < 8; i++)
      drive(i == 7, 1'b1, i == 0, i == 7);
    finish_frame("abort");
    ack("abort");
    check("abort_pulses", 32'(qv_pulses - pulses_before), 1);

    // Length boundary: exactly all-ones bits, then two beyond.
    push(8'h00, 4095, 1'b0);
    for (int i = 0; i < 4095; i++)
      drive(1'b0, 1'b1, i == 0, i == 4094);
    finish_frame("len_max");
    ack("len_max");
    push(8'h00, 4095, 1'b1);
    for (int i = 0; i < 4097; i++)
      drive(1'b0, 1'b1, i == 0, i == 4096);
    finish_frame("len_ovf");
    ack("len_ovf");
    check("retain_len", 32'(LEN), 4095);
    check("retain_lenovf", 32'(LENOVF), 1);
    push(8'h07, 1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    finish_frame("after_ovf");
    ack("after_ovf");

`ifdef CPLD_CRC8_CHECK_EN
    exp_in = 8'hF4;
    push(8'hF4, 72, 1'b0);
    for (int i = 0; i < 72; i++)
      drive(vecs[1].bits[71-i], 1'b1, i == 0, i == 71);
    finish_frame("chk_ok");
    ack("chk_ok");
    exp_in = 8'hF5;
    push(8'hF4, 72, 1'b0);
    for (int i = 0; i < 72; i++)
      drive(vecs[1].bits[71-i], 1'b1, i == 0, i == 71);
    finish_frame("chk_bad");
    check("chk_bad_err", 32'(err), 1);
    ack("chk_bad");
`endif

    // Reset in the middle of a frame, then a clean frame from INIT.
    for (int i = 0; i < 5; i++)
      drive(1'(i % 2), 1'b1, i == 0, 1'b0);
    @(negedge CLK);
    DV = 1'b0; SOF = 1'b0;
    RSTN = 1'b0;
    #1;
    check("mid_rst_qv", 32'(QV), 0);
    check("mid_rst_len", 32'(LEN), 0);
    check("mid_rst_rdy", 32'(RDY), 1);
    check("mid_rst_q", 32'(Q), 0);
    @(negedge CLK);
    RSTN = 1'b1;
    push(8'h89, 8, 1'b0);
    for (int i = 0; i < 8; i++)
      drive(i == 0, 1'b1, i == 0, i == 7);
    finish_frame("post_rst");
    ack("post_rst");

    repeat (2) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
